// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: IF stage that owns the PC, issues in-order fetches to
// instruction memory and buffers up to DEPTH {pc, instr} entries for decode.
//
// Optional feature macro: IFQ_BYPASS_EN. When it is defined, a response that
// fills the queue head is forwarded combinationally to the id_* outputs in the
// cycle it arrives. When it is undefined, id_* are driven only from stored
// entries.
//
// Handshake semantics: a transfer happens on a rising clk edge where valid and
// ready are both high. Valid never depends on ready on the same channel. The
// response channel has no ready: imem_rsp_valid is a one-cycle pulse carrying
// the oldest outstanding request's data.
module instruction_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_addr,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [XLEN-1:0]          imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [ILEN-1:0]          imem_rsp_data,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [XLEN-1:0]          id_pc,
    output logic [ILEN-1:0]          id_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Stale responses can pile up across back-to-back redirects, so the
    // drop counter is sized well beyond DEPTH.
    localparam int DW = 16;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   alloc_ptr;
    logic [PW-1:0]   fill_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occ_cnt;   // allocated entries (pending + filled)
    logic [CW-1:0]   pend_cnt;  // allocated entries still waiting for data
    logic [DW-1:0]   drop_cnt;  // in-flight responses that belong to a flushed stream

    logic req_fire;
    logic rsp_fill;
    logic rsp_drop;
    logic rsp_take;
    logic head_filled;
    logic bypass;
    logic pop;

    assign imem_req_valid = (occ_cnt < CW'(DEPTH)) && !redirect && !reset;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Entries are filled in allocation order, so the filled ones are always
    // the oldest; the head is filled whenever any entry is filled.
    assign head_filled = (occ_cnt != pend_cnt);
    assign rsp_fill    = imem_rsp_valid && (drop_cnt == '0) && (pend_cnt != '0);
    assign rsp_drop    = imem_rsp_valid && (drop_cnt != '0);
    // A response that is either dropped or fills an entry retires one
    // outstanding memory request; a response with nothing outstanding is ignored.
    assign rsp_take    = rsp_fill || rsp_drop;

`ifdef IFQ_BYPASS_EN
    assign bypass = rsp_fill && !head_filled;
`else
    assign bypass = 1'b0;
`endif

    assign id_valid  = head_filled || bypass;
    assign id_pc     = id_valid ? pc_mem[rd_ptr] : '0;
    assign id_instr  = bypass ? imem_rsp_data : (head_filled ? instr_mem[rd_ptr] : '0);
    assign pop       = id_valid && id_ready;
    assign occupancy = occ_cnt;

    // Entry storage: PC captured on request fire, instruction on response fill.
    always_ff @(posedge clk) begin
        if (!reset && !redirect) begin
            if (req_fire) begin
                pc_mem[alloc_ptr] <= pc;
            end
            if (rsp_fill && !(bypass && id_ready)) begin
                instr_mem[fill_ptr] <= imem_rsp_data;
            end
        end
    end

    // Control state: PC, pointers, counters; redirect flushes and reloads the PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occ_cnt   <= '0;
            pend_cnt  <= '0;
            drop_cnt  <= '0;
        end else if (redirect) begin
            pc        <= redirect_addr;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            rd_ptr    <= '0;
            occ_cnt   <= '0;
            pend_cnt  <= '0;
            // Every pending entry still has a response coming; the one that
            // arrives this very cycle is discarded now and needs no later drop.
            drop_cnt  <= drop_cnt + DW'(pend_cnt) - DW'(rsp_take);
        end else begin
            if (req_fire) begin
                alloc_ptr <= alloc_ptr + PW'(1);
                pc        <= pc + XLEN'(PC_STEP);
            end
            if (rsp_fill) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            occ_cnt  <= occ_cnt + CW'(req_fire) - CW'(pop);
            pend_cnt <= pend_cnt + CW'(req_fire) - CW'(rsp_fill);
        end
    end

endmodule
